// File: rtl/hazard_collision_unit_if.sv
// Bundle between the character controller / HUD side and the hazard collision unit.
// The master side drives character inputs and the frame tick; the slave side drives enemy and game status.
interface hazard_collision_unit_if;
  logic               tick;
  logic [2:0]         char_state;
  logic signed [10:0] posX;
  logic signed [10:0] posY;
  logic [10:0]        GroundY;
  logic signed [10:0] enemyX;
  logic [1:0]         enemy_state;
  logic               stomp;
  logic [7:0]         score;
  logic               game_over;

  modport master (
    output tick, char_state, posX, posY, GroundY,
    input  enemyX, enemy_state, stomp, score, game_over
  );

  modport slave (
    input  tick, char_state, posX, posY, GroundY,
    output enemyX, enemy_state, stomp, score, game_over
  );
endinterface

// File: rtl/hazard_collision_unit.sv
// One patrolling ground enemy plus one fixed pit, checked against the character once per frame tick.
// Build option ENEMY_RESPAWN_EN: a dead enemy respawns at the left patrol bound after RESPAWN_TICKS ticks.
module hazard_collision_unit #(
  parameter int ENEMY_X_MIN  = 200,
  parameter int ENEMY_X_MAX  = 400,
  parameter int ENEMY_SPEED  = 1,
  parameter int HIT_W        = 16,
  parameter int HIT_H        = 16,
  parameter int STOMP_MARGIN = 8,
  parameter int PIT_X_LO     = 520,
  parameter int PIT_X_HI     = 552,
  parameter int SQUASH_TICKS = 30
`ifdef ENEMY_RESPAWN_EN
  , parameter int RESPAWN_TICKS = 120
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_collision_unit_if.slave bus
);

  typedef enum logic [1:0] {
    PATROL_R = 2'd0,
    PATROL_L = 2'd1,
    SQUASHED = 2'd2,
    DEAD     = 2'd3
  } enemy_state_e;

  localparam int SQ_W = $clog2(SQUASH_TICKS + 1);
  localparam logic [SQ_W-1:0]   SQ_LOAD  = SQ_W'(SQUASH_TICKS - 1);
  localparam logic signed [11:0] XMIN_S  = 12'(ENEMY_X_MIN);
  localparam logic signed [11:0] XMAX_S  = 12'(ENEMY_X_MAX);
  localparam logic signed [11:0] SPEED_S = 12'(ENEMY_SPEED);
  localparam logic [11:0]        HIT_W_U = 12'(HIT_W);
  localparam logic [11:0]        HIT_H_U = 12'(HIT_H);
  localparam logic signed [11:0] MARGIN_S = 12'(STOMP_MARGIN);
  localparam logic signed [11:0] PIT_LO_S = 12'(PIT_X_LO);
  localparam logic signed [11:0] PIT_HI_S = 12'(PIT_X_HI);

  enemy_state_e       state_q, state_d;
  logic signed [10:0] x_q, x_d;
  logic [SQ_W-1:0]    sq_q, sq_d;
  logic [7:0]         score_q, score_d;
  logic               go_q, go_d;
  logic               stomp_q, stomp_d;

`ifdef ENEMY_RESPAWN_EN
  localparam int RS_W = $clog2(RESPAWN_TICKS + 1);
  localparam logic [RS_W-1:0] RS_LOAD = RS_W'(RESPAWN_TICKS - 1);
  logic [RS_W-1:0] rs_q, rs_d;
`endif

  // All geometry is done in 12-bit signed so differences of 11-bit values cannot overflow.
  logic signed [11:0] px_s, py_s, gy_s, ex_s;
  logic signed [11:0] dx_raw, dy_raw, x_inc, x_dec;
  logic [11:0]        dx_abs, dy_abs;
  logic               det_en, alive, overlap, stomp_c, hit, pit, do_stomp;

  assign px_s   = {bus.posX[10], bus.posX};
  assign py_s   = {bus.posY[10], bus.posY};
  assign gy_s   = {bus.GroundY[10], bus.GroundY};
  assign ex_s   = {x_q[10], x_q};
  assign dx_raw = px_s - ex_s;
  assign dy_raw = py_s - gy_s;
  assign dx_abs = dx_raw[11] ? $unsigned(-dx_raw) : $unsigned(dx_raw);
  assign dy_abs = dy_raw[11] ? $unsigned(-dy_raw) : $unsigned(dy_raw);
  assign x_inc  = ex_s + SPEED_S;
  assign x_dec  = ex_s - SPEED_S;

  assign det_en   = bus.char_state inside {3'd1, 3'd2, 3'd3};
  assign alive    = (state_q == PATROL_R) || (state_q == PATROL_L);
  assign overlap  = det_en && alive && (dx_abs < HIT_W_U) && (dy_abs < HIT_H_U);
  assign stomp_c  = overlap && (py_s <= gy_s - MARGIN_S);
  assign hit      = overlap && !stomp_c;
  assign pit      = det_en && (px_s >= PIT_LO_S) && (px_s <= PIT_HI_S) && (py_s >= gy_s);
  // A loss on the same tick, or an earlier loss, cancels the stomp entirely.
  assign do_stomp = stomp_c && !pit && !go_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    sq_d    = sq_q;
    score_d = score_q;
    go_d    = go_q;
    stomp_d = 1'b0;
`ifdef ENEMY_RESPAWN_EN
    rs_d    = rs_q;
`endif
    if (bus.tick) begin
      if (hit || pit) begin
        go_d = 1'b1;
      end
      if (do_stomp) begin
        stomp_d = 1'b1;
        if (score_q != 8'hFF) begin
          score_d = score_q + 8'd1;
        end
        state_d = SQUASHED;
        sq_d    = SQ_LOAD;
      end else begin
        unique case (state_q)
          PATROL_R: begin
            if (x_inc >= XMAX_S) begin
              x_d     = XMAX_S[10:0];
              state_d = PATROL_L;
            end else begin
              x_d = x_inc[10:0];
            end
          end
          PATROL_L: begin
            if (x_dec <= XMIN_S) begin
              x_d     = XMIN_S[10:0];
              state_d = PATROL_R;
            end else begin
              x_d = x_dec[10:0];
            end
          end
          SQUASHED: begin
            if (sq_q == '0) begin
              state_d = DEAD;
`ifdef ENEMY_RESPAWN_EN
              rs_d    = RS_LOAD;
`endif
            end else begin
              sq_d = sq_q - SQ_W'(1);
            end
          end
          DEAD: begin
`ifdef ENEMY_RESPAWN_EN
            if (rs_q == '0) begin
              state_d = PATROL_R;
              x_d     = XMIN_S[10:0];
            end else begin
              rs_d = rs_q - RS_W'(1);
            end
`endif
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PATROL_R;
      x_q     <= XMIN_S[10:0];
      sq_q    <= '0;
      score_q <= '0;
      go_q    <= 1'b0;
      stomp_q <= 1'b0;
`ifdef ENEMY_RESPAWN_EN
      rs_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sq_q    <= sq_d;
      score_q <= score_d;
      go_q    <= go_d;
      stomp_q <= stomp_d;
`ifdef ENEMY_RESPAWN_EN
      rs_q    <= rs_d;
`endif
    end
  end

  assign bus.enemyX      = x_q;
  assign bus.enemy_state = state_q;
  assign bus.stomp       = stomp_q;
  assign bus.score       = score_q;
  assign bus.game_over   = go_q;

endmodule
